// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IF fetch and MEM data share one memory port (optional round-robin via MEM_ARBITER_RR_EN).
// Latency: request sampled in IDLE -> m_req_o next cycle -> done one cycle after m_ack_i; minimum 3 cycles per transaction.
// Backpressure: stalls each pipeline stage while its request is pending; memory throttles via m_ack_i; one transaction in flight.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // instruction side
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_done_o,
    output logic              if_stall_o,
    // data side
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_done_o,
    output logic              d_stall_o,
    // shared memory
    output logic              m_req_o,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic [DATA_W-1:0] m_rdata_i,
    input  logic              m_ack_i,
    // status
    output logic              busy_o,
    output logic              grant_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    logic   w_any_req;
    logic   w_pick_d;

`ifdef MEM_ARBITER_RR_EN
    // 1 = data port owned the most recent grant, 0 = IF port
    logic   r_last_d;

    // On a tie, hand the memory to whichever port did not win last time
    always_comb begin
        w_any_req = if_req_i | d_req_i;
        if (if_req_i && d_req_i) begin
            w_pick_d = ~r_last_d;
        end else begin
            w_pick_d = d_req_i;
        end
    end

    // Remember the owner of every grant so ties alternate
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_last_d <= 1'b0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    // Fixed priority: the data port always wins a tie
    always_comb begin
        w_any_req = if_req_i | d_req_i;
        w_pick_d  = d_req_i;
    end
`endif

    // Stalls drop in the same cycle as the done pulse so the stage can advance
    assign if_stall_o = if_req_i & ~if_done_o;
    assign d_stall_o  = d_req_i  & ~d_done_o;

    // Arbitration FSM; every output is registered here
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            m_req_o    <= 1'b0;
            m_we_o     <= 1'b0;
            m_addr_o   <= '0;
            m_wdata_o  <= '0;
            if_rdata_o <= '0;
            d_rdata_o  <= '0;
            if_done_o  <= 1'b0;
            d_done_o   <= 1'b0;
            busy_o     <= 1'b0;
            grant_o    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        // Latch the winner's operands so later requester changes cannot disturb the bus
                        grant_o <= w_pick_d;
                        m_req_o <= 1'b1;
                        busy_o  <= 1'b1;
                        r_state <= S_GRANT;
                        if (w_pick_d) begin
                            m_we_o    <= d_we_i;
                            m_addr_o  <= d_addr_i;
                            m_wdata_o <= d_wdata_i;
                        end else begin
                            m_we_o    <= 1'b0;
                            m_addr_o  <= if_addr_i;
                            m_wdata_o <= '0;
                        end
                    end
                end
                S_GRANT: begin
                    // Completes even if the owner has since dropped its request
                    if (m_ack_i) begin
                        m_req_o <= 1'b0;
                        r_state <= S_DONE;
                        if (grant_o) begin
                            d_done_o <= 1'b1;
                            if (!m_we_o) begin
                                d_rdata_o <= m_rdata_i;
                            end
                        end else begin
                            if_done_o  <= 1'b1;
                            if_rdata_o <= m_rdata_i;
                        end
                    end
                end
                S_DONE: begin
                    if_done_o <= 1'b0;
                    d_done_o  <= 1'b0;
                    busy_o    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    m_req_o   <= 1'b0;
                    if_done_o <= 1'b0;
                    d_done_o  <= 1'b0;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Inputs are driven and outputs sampled on the falling clock edge.
// Define MEM_ARBITER_RR_EN for both RTL and bench to exercise round-robin ties.
module tb_mem_arbiter;

    logic        clk_i;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_done_o;
    logic        if_stall_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_done_o;
    logic        d_stall_o;
    logic        m_req_o;
    logic        m_we_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic [31:0] m_rdata_i;
    logic        m_ack_i;
    logic        busy_o;
    logic        grant_o;

    int n_tests;
    int n_fail;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .if_done_o(if_done_o), .if_stall_o(if_stall_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_rdata_o(d_rdata_o), .d_done_o(d_done_o), .d_stall_o(d_stall_o),
        .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
        .m_rdata_i(m_rdata_i), .m_ack_i(m_ack_i),
        .busy_o(busy_o), .grant_o(grant_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Mutual exclusion of the done pulses, checked every cycle
    always @(negedge clk_i) begin
        if (rst_i) begin
            n_tests++;
            if ((if_done_o & d_done_o) !== 1'b0) begin
                n_fail++;
                $display("FAIL done_exclusive: if_done=%b d_done=%b, required not both 1", if_done_o, d_done_o);
            end
        end
    end

    task automatic test_reset();
        rst_i = 1'b0;
        if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_wdata_i = 0;
        m_rdata_i = 0; m_ack_i = 0;
        @(negedge clk_i); @(negedge clk_i);
        n_tests++;
        if ({m_req_o, m_we_o, if_done_o, d_done_o, busy_o, grant_o, if_stall_o, d_stall_o} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 00000000",
                     {m_req_o, m_we_o, if_done_o, d_done_o, busy_o, grant_o, if_stall_o, d_stall_o});
        end
        n_tests++;
        if ({m_addr_o, m_wdata_o, if_rdata_o, d_rdata_o} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, required 0", {m_addr_o, m_wdata_o, if_rdata_o, d_rdata_o});
        end
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_if_read();
        if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
        @(negedge clk_i); // cycle 1
        n_tests++;
        if ({m_req_o, m_we_o, busy_o, grant_o, if_stall_o} !== 5'b10101 || m_addr_o !== 32'h10) begin
            n_fail++;
            $display("FAIL if_read_grant: req/we/busy/grant/stall=%b addr=%h, required 10101 addr=00000010",
                     {m_req_o, m_we_o, busy_o, grant_o, if_stall_o}, m_addr_o);
        end
        @(negedge clk_i); // cycle 2
        n_tests++;
        if ({m_req_o, if_done_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL if_read_wait: req/done=%b, required 10", {m_req_o, if_done_o});
        end
        @(negedge clk_i); // cycle 3: ack two cycles after m_req_o
        m_ack_i = 1'b1; m_rdata_i = 32'h1234_5678;
        @(negedge clk_i); // cycle 4
        m_ack_i = 1'b0; m_rdata_i = 32'h0;
        n_tests++;
        if ({if_done_o, d_done_o, if_stall_o, m_req_o} !== 4'b1000 || if_rdata_o !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL if_read_done: done/ddone/stall/req=%b rdata=%h, required 1000 rdata=12345678",
                     {if_done_o, d_done_o, if_stall_o, m_req_o}, if_rdata_o);
        end
        if_req_i = 1'b0;
        @(negedge clk_i); // cycle 5
        n_tests++;
        if ({if_done_o, busy_o} !== 2'b00 || if_rdata_o !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL if_read_idle: done/busy=%b rdata=%h, required 00 rdata=12345678",
                     {if_done_o, busy_o}, if_rdata_o);
        end
    endtask

    task automatic test_d_read();
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h80; d_wdata_i = 32'h0;
        @(negedge clk_i);
        n_tests++;
        if ({m_req_o, m_we_o, grant_o} !== 3'b101 || m_addr_o !== 32'h80) begin
            n_fail++;
            $display("FAIL d_read_grant: req/we/grant=%b addr=%h, required 101 addr=00000080",
                     {m_req_o, m_we_o, grant_o}, m_addr_o);
        end
        m_ack_i = 1'b1; m_rdata_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        m_ack_i = 1'b0; m_rdata_i = 32'h0;
        n_tests++;
        if ({d_done_o, if_done_o} !== 2'b10 || d_rdata_o !== 32'hCAFE_F00D || if_rdata_o !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL d_read_done: done=%b drdata=%h ifrdata=%h, required 10 cafef00d 12345678",
                     {d_done_o, if_done_o}, d_rdata_o, if_rdata_o);
        end
        d_req_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_d_write();
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h40; d_wdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i); // cycle 1: ack in the same cycle as m_req_o
        n_tests++;
        if ({m_req_o, m_we_o, grant_o} !== 3'b111 || m_addr_o !== 32'h40 || m_wdata_o !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL d_write_grant: req/we/grant=%b addr=%h wdata=%h, required 111 00000040 deadbeef",
                     {m_req_o, m_we_o, grant_o}, m_addr_o, m_wdata_o);
        end
        m_ack_i = 1'b1; m_rdata_i = 32'h5555_5555;
        @(negedge clk_i); // cycle 2
        m_ack_i = 1'b0; m_rdata_i = 32'h0;
        n_tests++;
        if ({d_done_o, if_done_o, d_stall_o} !== 3'b100 || d_rdata_o !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL d_write_done: done/ifdone/stall=%b drdata=%h, required 100 cafef00d",
                     {d_done_o, if_done_o, d_stall_o}, d_rdata_o);
        end
        d_req_i = 1'b0; d_we_i = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if ({d_done_o, busy_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL d_write_idle: done/busy=%b, required 00", {d_done_o, busy_o});
        end
    endtask

    task automatic test_ack_ignored();
        m_ack_i = 1'b1; m_rdata_i = 32'hFFFF_0000;
        @(negedge clk_i);
        @(negedge clk_i);
        m_ack_i = 1'b0; m_rdata_i = 32'h0;
        n_tests++;
        if ({m_req_o, busy_o, if_done_o, d_done_o} !== 4'b0000 || d_rdata_o !== 32'hCAFE_F00D ||
            if_rdata_o !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL ack_idle: req/busy/dones=%b if=%h d=%h, required 0000 12345678 cafef00d",
                     {m_req_o, busy_o, if_done_o, d_done_o}, if_rdata_o, d_rdata_o);
        end
    endtask

    task automatic test_tie();
        logic [2:0]  exp_seq;
        logic        own;
        logic [31:0] dat;
`ifdef MEM_ARBITER_RR_EN
        exp_seq = 3'b101; // bit t = 1 -> data port owns transaction t
`else
        exp_seq = 3'b111;
`endif
        // fresh reset so the pointer starts at "IF last"
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        if_req_i = 1'b1; if_addr_i = 32'h100;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h200;
        for (int t = 0; t < 3; t++) begin
            own = exp_seq[t];
            dat = 32'hA000_0000 + t;
            @(negedge clk_i); // cycle 1
            n_tests++;
            if (grant_o !== own || m_req_o !== 1'b1 || m_addr_o !== (own ? 32'h200 : 32'h100) ||
                if_stall_o !== 1'b1 || d_stall_o !== 1'b1) begin
                n_fail++;
                $display("FAIL tie_grant[%0d]: grant=%b req=%b addr=%h stalls=%b%b, required grant=%b req=1 stalls=11",
                         t, grant_o, m_req_o, m_addr_o, if_stall_o, d_stall_o, own);
            end
            m_ack_i = 1'b1; m_rdata_i = dat;
            @(negedge clk_i); // cycle 2
            m_ack_i = 1'b0; m_rdata_i = 32'h0;
            n_tests++;
            if ({d_done_o, if_done_o} !== {own, ~own} || if_stall_o !== own ||
                (own ? d_rdata_o : if_rdata_o) !== dat) begin
                n_fail++;
                $display("FAIL tie_done[%0d]: ddone/ifdone=%b ifstall=%b rdata=%h, required %b%b %b %h",
                         t, {d_done_o, if_done_o}, if_stall_o, own ? d_rdata_o : if_rdata_o, own, ~own, own, dat);
            end
            @(negedge clk_i); // cycle 3: back in IDLE, requests still held
            n_tests++;
            if (busy_o !== 1'b0 || m_req_o !== 1'b0) begin
                n_fail++;
                $display("FAIL tie_idle[%0d]: busy=%b req=%b, required 0 0", t, busy_o, m_req_o);
            end
        end
        if_req_i = 1'b0; d_req_i = 1'b0;
        @(negedge clk_i); // drains the grant taken on the last idle cycle
        m_ack_i = 1'b1;
        @(negedge clk_i);
        m_ack_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid_grant();
        if_req_i = 1'b1; if_addr_i = 32'h20;
        @(negedge clk_i); // cycle 1: m_req_o up
        n_tests++;
        if (m_req_o !== 1'b1 || m_addr_o !== 32'h20) begin
            n_fail++;
            $display("FAIL rst_grant_setup: req=%b addr=%h, required 1 00000020", m_req_o, m_addr_o);
        end
        @(negedge clk_i); // one cycle after m_req_o
        rst_i = 1'b0; if_req_i = 1'b0;
        #1;
        n_tests++;
        if ({m_req_o, busy_o, grant_o, if_done_o} !== 4'b0000 || m_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_grant: req/busy/grant/done=%b addr=%h, required 0000 00000000",
                     {m_req_o, busy_o, grant_o, if_done_o}, m_addr_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        m_ack_i = 1'b1; m_rdata_i = 32'h7777_7777; // late ack after release
        @(negedge clk_i);
        m_ack_i = 1'b0; m_rdata_i = 32'h0;
        n_tests++;
        if ({if_done_o, d_done_o, busy_o, m_req_o} !== 4'b0000 || if_rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_late_ack: dones/busy/req=%b rdata=%h, required 0000 00000000",
                     {if_done_o, d_done_o, busy_o, m_req_o}, if_rdata_o);
        end
        @(negedge clk_i);
        n_tests++;
        if ({if_done_o, busy_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_after: done/busy=%b, required 00", {if_done_o, busy_o});
        end
    endtask

    task automatic test_dropped_req();
        if_req_i = 1'b1; if_addr_i = 32'h30;
        @(negedge clk_i); // cycle 1
        n_tests++;
        if ({m_req_o, grant_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL drop_grant: req/grant=%b, required 10", {m_req_o, grant_o});
        end
        if_req_i = 1'b0; if_addr_i = 32'h999;
        @(negedge clk_i); // cycle 2
        n_tests++;
        if (m_req_o !== 1'b1 || m_addr_o !== 32'h30 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_hold: req=%b addr=%h busy=%b, required 1 00000030 1", m_req_o, m_addr_o, busy_o);
        end
        m_ack_i = 1'b1; m_rdata_i = 32'h0BAD_F00D;
        @(negedge clk_i); // cycle 3
        m_ack_i = 1'b0; m_rdata_i = 32'h0;
        n_tests++;
        if ({if_done_o, d_done_o, if_stall_o} !== 3'b100 || if_rdata_o !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL drop_done: done/ddone/stall=%b rdata=%h, required 100 0badf00d",
                     {if_done_o, d_done_o, if_stall_o}, if_rdata_o);
        end
        @(negedge clk_i); // cycle 4
        n_tests++;
        if ({if_done_o, busy_o, m_req_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL drop_idle: done/busy/req=%b, required 000", {if_done_o, busy_o, m_req_o});
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_if_read();
        test_d_read();
        test_d_write();
        test_ack_ignored();
        test_tie();
        test_reset_mid_grant();
        test_dropped_req();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
